// File: rtl/pmem_pkg.sv
// Shared constants and state encoding for the cache-line to burst-memory adaptor.
package pmem_pkg;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int OFFSET_BITS = $clog2(LINE_W / 8);
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Clears the byte-offset bits so the burst always starts on a line boundary.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide working register: full-line load for write data, per-beat write for
// read assembly, and a beat select for the outgoing write beat.
module line_beat_buffer
    import pmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               beat_we_i,
    input  logic [CNT_W-1:0]   beat_idx_i,
    input  logic [BURST_W-1:0] beat_i,
    output logic [LINE_W-1:0]  line_o,
    output logic [BURST_W-1:0] beat_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = line_i;
        end else if (beat_we_i) begin
            line_d[beat_idx_i*BURST_W +: BURST_W] = beat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[beat_idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/line_burst_adaptor.sv
// Responder on the cache physical-memory port: splits each line request into
// BEATS sequential beats on the narrow burst memory and pulses pmem_resp at the end.
module line_burst_adaptor
    import pmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               mem_burst_read,
    output logic               mem_burst_write,
    output logic [ADDR_W-1:0]  mem_burst_addr,
    output logic [BURST_W-1:0] mem_burst_wdata,
    input  logic [BURST_W-1:0] mem_burst_rdata,
    input  logic               mem_burst_resp
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               is_rd_q, is_rd_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;

    logic               buf_load;
    logic               buf_we;
    logic [LINE_W-1:0]  buf_line;
    logic [BURST_W-1:0] buf_beat;
    logic               last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    line_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (buf_load),
        .line_i     (pmem_wdata),
        .beat_we_i  (buf_we),
        .beat_idx_i (cnt_q),
        .beat_i     (mem_burst_rdata),
        .line_o     (buf_line),
        .beat_o     (buf_beat)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        is_rd_d         = is_rd_q;
        rdata_d         = rdata_q;
        buf_load        = 1'b0;
        buf_we          = 1'b0;
        pmem_resp       = 1'b0;
        mem_burst_read  = 1'b0;
        mem_burst_write = 1'b0;
        mem_burst_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A simultaneous read and write resolves in favour of the write.
                if (pmem_write) begin
                    addr_d   = line_align(pmem_address);
                    buf_load = 1'b1;
                    is_rd_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_WR_BURST;
                end else if (pmem_read) begin
                    addr_d  = line_align(pmem_address);
                    is_rd_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                mem_burst_read = 1'b1;
                if (mem_burst_resp) begin
                    buf_we = 1'b1;
                    cnt_d  = last_beat ? '0 : cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WR_BURST: begin
                mem_burst_write = 1'b1;
                mem_burst_wdata = buf_beat;
                if (mem_burst_resp) begin
                    cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                pmem_resp = 1'b1;
                // Captured here so the read line stays put through later writes.
                if (is_rd_q) begin
                    rdata_d = buf_line;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            is_rd_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            is_rd_q <= is_rd_d;
            rdata_q <= rdata_d;
        end
    end

    // During the completion cycle of a read the freshly assembled line is shown directly.
    assign pmem_rdata     = (state_q == ST_DONE && is_rd_q) ? buf_line : rdata_q;
    assign mem_burst_addr = addr_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: reads, gapped writes, back-to-back
// write/read, read-vs-write priority, async reset mid-burst and stray beat responses.
module tb_line_burst_adaptor;
    import pmem_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               pmem_read;
    logic               pmem_write;
    logic [ADDR_W-1:0]  pmem_address;
    logic [LINE_W-1:0]  pmem_wdata;
    logic [LINE_W-1:0]  pmem_rdata;
    logic               pmem_resp;
    logic               mem_burst_read;
    logic               mem_burst_write;
    logic [ADDR_W-1:0]  mem_burst_addr;
    logic [BURST_W-1:0] mem_burst_wdata;
    logic [BURST_W-1:0] mem_burst_rdata;
    logic               mem_burst_resp;

    int errors = 0;
    int checks = 0;

    line_burst_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .mem_burst_read  (mem_burst_read),
        .mem_burst_write (mem_burst_write),
        .mem_burst_addr  (mem_burst_addr),
        .mem_burst_wdata (mem_burst_wdata),
        .mem_burst_rdata (mem_burst_rdata),
        .mem_burst_resp  (mem_burst_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Supplies one read beat; entered and left at a falling edge.
    task automatic rd_beat(input logic [BURST_W-1:0] d);
        chk("rd_active", LINE_W'(mem_burst_read), LINE_W'(1));
        chk("rd_no_resp", LINE_W'(pmem_resp), LINE_W'(0));
        mem_burst_resp  = 1'b1;
        mem_burst_rdata = d;
        @(posedge clk);
        @(negedge clk);
        mem_burst_resp  = 1'b0;
        mem_burst_rdata = '0;
    endtask

    // Holds off the beat response for gap cycles, checking the write beat is held.
    task automatic wr_beat(input int gap, input logic [BURST_W-1:0] exp);
        for (int i = 0; i < gap; i++) begin
            chk("wr_hold_data", LINE_W'(mem_burst_wdata), LINE_W'(exp));
            chk("wr_hold_no_resp", LINE_W'(pmem_resp), LINE_W'(0));
            @(posedge clk);
            @(negedge clk);
        end
        chk("wr_data", LINE_W'(mem_burst_wdata), LINE_W'(exp));
        chk("wr_active", LINE_W'(mem_burst_write), LINE_W'(1));
        chk("wr_no_read", LINE_W'(mem_burst_read), LINE_W'(0));
        mem_burst_resp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_burst_resp = 1'b0;
    endtask

    localparam logic [LINE_W-1:0] L1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                        64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    localparam logic [LINE_W-1:0] L2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [LINE_W-1:0] L3 = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                                        64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210};
    localparam logic [LINE_W-1:0] L4 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                        64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [LINE_W-1:0] L5 = {64'hEEEE_EEEE_EEEE_EEEE, 64'h9999_9999_9999_9999,
                                        64'h4444_4444_4444_4444, 64'h1010_1010_1010_1010};
    localparam logic [LINE_W-1:0] L6 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                        64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    localparam logic [LINE_W-1:0] L7 = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                                        64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};

    initial begin
        rst             = 1'b1;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = '0;
        pmem_wdata      = '0;
        mem_burst_rdata = '0;
        mem_burst_resp  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_resp", LINE_W'(pmem_resp), LINE_W'(0));
        chk("reset_rdata", pmem_rdata, '0);
        chk("reset_rd", LINE_W'(mem_burst_read), LINE_W'(0));
        chk("reset_wr", LINE_W'(mem_burst_write), LINE_W'(0));
        chk("reset_addr", LINE_W'(mem_burst_addr), LINE_W'(0));
        chk("reset_wdata", LINE_W'(mem_burst_wdata), LINE_W'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: read with back-to-back beats
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        chk("t1_addr", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_1220));
        chk("t1_no_wr", LINE_W'(mem_burst_write), LINE_W'(0));
        rd_beat(64'h0000_0000_0000_0000);
        rd_beat(64'h1111_1111_1111_1111);
        rd_beat(64'h2222_2222_2222_2222);
        rd_beat(64'h3333_3333_3333_3333);
        chk("t1_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t1_rdata", pmem_rdata, L1);
        chk("t1_done_rd", LINE_W'(mem_burst_read), LINE_W'(0));
        pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t1_resp_one_cycle", LINE_W'(pmem_resp), LINE_W'(0));
        chk("t1_rdata_held", pmem_rdata, L1);

        // 2: write with response gaps; request inputs disturbed after accept
        pmem_write   = 1'b1;
        pmem_wdata   = L2;
        pmem_address = 32'h0000_8008;
        @(posedge clk);
        @(negedge clk);
        pmem_wdata   = '1;
        pmem_address = 32'hFFFF_FFFF;
        chk("t2_addr", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_8000));
        wr_beat(0, 64'hAAAA_AAAA_AAAA_AAAA);
        wr_beat(2, 64'hBBBB_BBBB_BBBB_BBBB);
        pmem_write = 1'b0;
        wr_beat(3, 64'hCCCC_CCCC_CCCC_CCCC);
        chk("t2_addr_stable", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_8000));
        wr_beat(1, 64'hDDDD_DDDD_DDDD_DDDD);
        chk("t2_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t2_done_wr", LINE_W'(mem_burst_write), LINE_W'(0));
        chk("t2_rdata_kept", pmem_rdata, L1);
        @(posedge clk);
        @(negedge clk);
        chk("t2_resp_one_cycle", LINE_W'(pmem_resp), LINE_W'(0));
        chk("t2_idle_wr", LINE_W'(mem_burst_write), LINE_W'(0));

        // 3: write-back followed immediately by refill
        pmem_write   = 1'b1;
        pmem_wdata   = L3;
        pmem_address = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        wr_beat(0, 64'hFEDC_BA98_7654_3210);
        wr_beat(0, 64'h1234_5678_9ABC_DEF0);
        wr_beat(0, 64'hF0F0_F0F0_F0F0_F0F0);
        wr_beat(0, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("t3_wr_resp", LINE_W'(pmem_resp), LINE_W'(1));
        @(posedge clk);
        @(negedge clk);
        chk("t3_idle_no_resp", LINE_W'(pmem_resp), LINE_W'(0));
        pmem_write   = 1'b0;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_2047;
        @(posedge clk);
        @(negedge clk);
        chk("t3_rd_start", LINE_W'(mem_burst_read), LINE_W'(1));
        chk("t3_addr", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_2040));
        rd_beat(64'h5555_5555_5555_5555);
        rd_beat(64'h6666_6666_6666_6666);
        rd_beat(64'h7777_7777_7777_7777);
        rd_beat(64'h8888_8888_8888_8888);
        chk("t3_rd_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t3_rdata", pmem_rdata, L4);
        pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // 4: read and write both asserted
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_wdata   = L5;
        pmem_address = 32'h0000_3000;
        @(posedge clk);
        @(negedge clk);
        chk("t4_write_wins", LINE_W'(mem_burst_write), LINE_W'(1));
        wr_beat(0, 64'h1010_1010_1010_1010);
        wr_beat(0, 64'h4444_4444_4444_4444);
        wr_beat(0, 64'h9999_9999_9999_9999);
        wr_beat(0, 64'hEEEE_EEEE_EEEE_EEEE);
        chk("t4_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t4_rdata_kept", pmem_rdata, L4);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_no_extra_rd", LINE_W'(mem_burst_read), LINE_W'(0));

        // 5: asynchronous reset after two read beats
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_4000;
        @(posedge clk);
        @(negedge clk);
        rd_beat(64'hDEAD_DEAD_DEAD_DEAD);
        rd_beat(64'hBEEF_BEEF_BEEF_BEEF);
        rst = 1'b1;
        #1;
        chk("t5_rst_rd", LINE_W'(mem_burst_read), LINE_W'(0));
        chk("t5_rst_addr", LINE_W'(mem_burst_addr), LINE_W'(0));
        chk("t5_rst_rdata", pmem_rdata, '0);
        chk("t5_rst_resp", LINE_W'(pmem_resp), LINE_W'(0));
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_fresh_addr", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_4000));
        rd_beat(64'hA0A0_A0A0_A0A0_A0A0);
        rd_beat(64'hA1A1_A1A1_A1A1_A1A1);
        rd_beat(64'hA2A2_A2A2_A2A2_A2A2);
        rd_beat(64'hA3A3_A3A3_A3A3_A3A3);
        chk("t5_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t5_rdata", pmem_rdata, L6);
        pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // 6: stray beat responses while idle, then a clean read
        mem_burst_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t6_idle_resp", LINE_W'(pmem_resp), LINE_W'(0));
            chk("t6_idle_rd", LINE_W'(mem_burst_read), LINE_W'(0));
            chk("t6_idle_wr", LINE_W'(mem_burst_write), LINE_W'(0));
        end
        mem_burst_resp = 1'b0;
        pmem_read      = 1'b1;
        pmem_address   = 32'h0000_5010;
        @(posedge clk);
        @(negedge clk);
        chk("t6_addr", LINE_W'(mem_burst_addr), LINE_W'(32'h0000_5000));
        rd_beat(64'hC0DE_0000_0000_0000);
        rd_beat(64'hC0DE_0000_0000_0001);
        rd_beat(64'hC0DE_0000_0000_0002);
        rd_beat(64'hC0DE_0000_0000_0003);
        chk("t6_resp", LINE_W'(pmem_resp), LINE_W'(1));
        chk("t6_rdata", pmem_rdata, L7);
        pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_resp_one_cycle", LINE_W'(pmem_resp), LINE_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
